// File: rtl/dcpu16_mbus_arb.sv
// Round-robin arbiter sharing one Wishbone-style memory port between the
// fetch/store bus and the operand address bus, with a bus watchdog.
module dcpu16_mbus_arb #(
  parameter logic [7:0] TMO = 8'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_stb,
  input  logic        fs_wre,
  input  logic [15:0] fs_adr,
  input  logic [15:0] fs_dto,
  output logic        fs_ack,
  output logic [15:0] fs_dti,
  input  logic        ab_stb,
  input  logic        ab_wre,
  input  logic [15:0] ab_adr,
  input  logic [15:0] ab_dto,
  output logic        ab_ack,
  output logic [15:0] ab_dti,
  output logic        err,
  output logic        ena,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSF = 2'd1,
    BUSA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        last_r, last_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        grant_ab_s;
  logic        cyc_s, we_s, fs_ack_s, ab_ack_s, err_s;
  logic [15:0] adr_s, dat_s, fs_dti_s, ab_dti_s;

  // AB wins when it is the only requester or when FS was served last.
  assign grant_ab_s = ab_stb & (~fs_stb | ~last_r);

  assign ena = (state_r == IDLE) & ~fs_stb & ~ab_stb;

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    state_s  = state_r;
    last_s   = last_r;
    cnt_s    = cnt_r;
    cyc_s    = wb_cyc_o;
    we_s     = wb_we_o;
    adr_s    = wb_adr_o;
    dat_s    = wb_dat_o;
    fs_dti_s = fs_dti;
    ab_dti_s = ab_dti;
    fs_ack_s = 1'b0;
    ab_ack_s = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fs_stb | ab_stb) begin
          cyc_s = 1'b1;
          cnt_s = 8'd0;
          if (grant_ab_s) begin
            adr_s   = ab_adr;
            we_s    = ab_wre;
            dat_s   = ab_dto;
            state_s = BUSA;
          end else begin
            adr_s   = fs_adr;
            we_s    = fs_wre;
            dat_s   = fs_dto;
            state_s = BUSF;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSF, BUSA: begin
        // A real ack takes precedence over a watchdog expiry in the same cycle.
        if (wb_ack_i || (cnt_r == TMO - 8'd1)) begin
          cyc_s   = 1'b0;
          err_s   = ~wb_ack_i;
          last_s  = (state_r == BUSA);
          state_s = DONE;
          if (state_r == BUSA) begin
            ab_ack_s = 1'b1;
            if (wb_ack_i && !wb_we_o) begin
              ab_dti_s = wb_dat_i;
            end else begin
              ab_dti_s = ab_dti;
            end
          end else begin
            fs_ack_s = 1'b1;
            if (wb_ack_i && !wb_we_o) begin
              fs_dti_s = wb_dat_i;
            end else begin
              fs_dti_s = fs_dti;
            end
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      last_r   <= 1'b0;
      cnt_r    <= 8'd0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= 16'h0000;
      wb_dat_o <= 16'h0000;
      fs_dti   <= 16'h0000;
      ab_dti   <= 16'h0000;
      fs_ack   <= 1'b0;
      ab_ack   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_r  <= state_s;
      last_r   <= last_s;
      cnt_r    <= cnt_s;
      wb_cyc_o <= cyc_s;
      wb_stb_o <= cyc_s;
      wb_we_o  <= we_s;
      wb_adr_o <= adr_s;
      wb_dat_o <= dat_s;
      fs_dti   <= fs_dti_s;
      ab_dti   <= ab_dti_s;
      fs_ack   <= fs_ack_s;
      ab_ack   <= ab_ack_s;
      err      <= err_s;
    end
  end

endmodule
